mv_pred_decoder: RTL and testbench

Multi-channel, pipelined MPEG motion-vector reconstruction unit. It keeps one predictor register per vector component, for example forward/backward × horizontal/vertical. For each accepted (motion_code, motion_residual) pair it forms the differential, adds it to the predictor with modular wrap-around, updates the predictor and emits the reconstructed half-pel vector. It sits between the macroblock-header VLC parser and motion compensation, and takes r_size and full_pel per transaction rather than as a compile-time constant.

---
 rtl/mv_pred_decoder.sv | 161 ++++++++++++++++
 tb/tb_mv_pred_decoder.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mv_pred_decoder.sv
// mv_pred_decoder: two-stage MPEG motion-vector reconstruction with one
// predictor register per channel. Stage A decodes the differential from
// (motion_code, residual, r_size). Stage B adds it to the channel predictor
// with modular wrap-around, writes the predictor back and presents the result.
module mv_pred_decoder #(
  parameter int NUM_CH     = 4,
  parameter int VEC_W      = 16,
  parameter int MAX_R_SIZE = 6,
  parameter int CH_W       = $clog2(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr_pred,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic        [CH_W-1:0]       in_ch,
  input  logic        [2:0]            in_r_size,
  input  logic                         in_full_pel,
  input  logic signed [5:0]            in_motion_code,
  input  logic        [MAX_R_SIZE-1:0] in_motion_residual,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic        [CH_W-1:0]       out_ch,
  output logic signed [VEC_W-1:0]      out_vec,
  output logic                         out_err
);

  // Two guard bits so base + delta and the wrap correction cannot overflow.
  localparam int IW = VEC_W + 2;

  // Signed differential: sign(code) * (((|code|-1) << r) + (res & mask) + 1).
  function automatic logic signed [IW-1:0] motion_delta(
    input logic signed [5:0]            code,
    input logic        [2:0]            r,
    input logic        [MAX_R_SIZE-1:0] res
  );
    logic signed [IW-1:0] code_x;
    logic signed [IW-1:0] mag_code;
    logic signed [IW-1:0] mask;
    logic signed [IW-1:0] res_x;
    logic signed [IW-1:0] mag;
    code_x   = IW'(code);
    mag_code = code_x[IW-1] ? -code_x : code_x;
    mask     = (IW'(1) << r) - IW'(1);
    res_x    = IW'(res) & mask;
    mag      = ((mag_code - IW'(1)) << r) + res_x + IW'(1);
    return code_x[IW-1] ? -mag : mag;
  endfunction

  // Fold a sum back into [-lim, lim) with a single 2*lim correction.
  function automatic logic signed [IW-1:0] wrap_range(
    input logic signed [IW-1:0] s,
    input logic signed [IW-1:0] lim
  );
    logic signed [IW-1:0] w;
    if (s >= lim)       w = s - (lim <<< 1);
    else if (s < -lim)  w = s + (lim <<< 1);
    else                w = s;
    return w;
  endfunction

  logic                         vld_p0;
  logic        [CH_W-1:0]       ch_p0;
  logic        [2:0]            r_p0;
  logic                         full_pel_p0;
  logic                         zero_p0;
  logic                         err_p0;
  logic signed [IW-1:0]         delta_p0;

  logic                         vld_p1;
  logic        [CH_W-1:0]       ch_p1;
  logic signed [VEC_W-1:0]      vec_p1;
  logic                         err_p1;

  logic signed [VEC_W-1:0]      pred [NUM_CH];

  logic                         advance;
  logic        [6:0]            code_x7;
  logic        [6:0]            abs_code;
  logic                         err_a;
  logic signed [IW-1:0]         delta_a;

  logic signed [VEC_W-1:0]      pred_rd;
  logic signed [IW-1:0]         base_b;
  logic signed [IW-1:0]         lim_b;
  logic signed [IW-1:0]         v_b;
  logic signed [VEC_W-1:0]      vec_b;
  logic                         wr_b;

  assign advance   = !vld_p1 || out_ready;
  assign in_ready  = !vld_p0 || advance;
  assign out_valid = vld_p1;
  assign out_ch    = ch_p1;
  assign out_vec   = vec_p1;
  assign out_err   = err_p1;

  // Stage A decode: legality check and differential from the raw input fields.
  always_comb begin
    code_x7  = {in_motion_code[5], in_motion_code};
    abs_code = code_x7[6] ? -code_x7 : code_x7;
    err_a    = (abs_code > 7'd16) || (in_r_size > 3'(MAX_R_SIZE));
    delta_a  = motion_delta(in_motion_code, in_r_size, in_motion_residual);
  end

  // ---- Stage A boundary (p0) ----
  // Stage A occupancy: refills whenever the slot is empty or moving on.
  always_ff @(posedge clk) begin
    if (rst) vld_p0 <= 1'b0;
    else if (in_ready) vld_p0 <= in_valid;
  end

  // Stage A payload capture on an input transfer.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      ch_p0       <= in_ch;
      r_p0        <= in_r_size;
      full_pel_p0 <= in_full_pel;
      zero_p0     <= (in_motion_code == 6'sd0);
      err_p0      <= err_a;
      delta_p0    <= delta_a;
    end
  end

  // Stage B reconstruct: predictor read, full-pel scaling, wrap, write-back value.
  always_comb begin
    pred_rd = pred[ch_p0];
    base_b  = full_pel_p0 ? (IW'(pred_rd) >>> 1) : IW'(pred_rd);
    lim_b   = IW'(16) <<< r_p0;
    v_b     = zero_p0 ? base_b : wrap_range(base_b + delta_p0, lim_b);
    vec_b   = err_p0 ? pred_rd : VEC_W'(full_pel_p0 ? (v_b <<< 1) : v_b);
    wr_b    = vld_p0 && advance && !err_p0;
  end

  // ---- Stage B boundary (p1) ----
  // Output register: loads the Stage A result whenever the output slot frees.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      ch_p1  <= '0;
      vec_p1 <= '0;
      err_p1 <= 1'b0;
    end else if (advance) begin
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        ch_p1  <= ch_p0;
        vec_p1 <= vec_b;
        err_p1 <= err_p0;
      end
    end
  end

  // Predictor file: clear beats a same-edge write-back.
  always_ff @(posedge clk) begin
    if (rst || clr_pred) begin
      for (int i = 0; i < NUM_CH; i++) pred[i] <= '0;
    end else if (wr_b) begin
      pred[ch_p0] <= vec_b;
    end
  end

endmodule

// File: tb/tb_mv_pred_decoder.sv
// Testbench for mv_pred_decoder: directed scenarios plus randomized traffic
// scored against a behavioural predictor model.
module tb_mv_pred_decoder;

  localparam int NUM_CH     = 4;
  localparam int VEC_W      = 16;
  localparam int MAX_R_SIZE = 6;
  localparam int CH_W       = 2;

  logic                         clk = 1'b0;
  logic                         rst;
  logic                         clr_pred;
  logic                         in_valid;
  logic                         in_ready;
  logic        [CH_W-1:0]       in_ch;
  logic        [2:0]            in_r_size;
  logic                         in_full_pel;
  logic signed [5:0]            in_motion_code;
  logic        [MAX_R_SIZE-1:0] in_motion_residual;
  logic                         out_valid;
  logic                         out_ready;
  logic        [CH_W-1:0]       out_ch;
  logic signed [VEC_W-1:0]      out_vec;
  logic                         out_err;

  mv_pred_decoder #(
    .NUM_CH(NUM_CH), .VEC_W(VEC_W), .MAX_R_SIZE(MAX_R_SIZE), .CH_W(CH_W)
  ) dut (
    .clk(clk), .rst(rst), .clr_pred(clr_pred),
    .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch),
    .in_r_size(in_r_size), .in_full_pel(in_full_pel),
    .in_motion_code(in_motion_code), .in_motion_residual(in_motion_residual),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
    .out_vec(out_vec), .out_err(out_err)
  );

  always #5 clk = ~clk;

  typedef struct { int ch; int vec; int err; } exp_t;
  exp_t exp_q[$];
  int   model_pred [NUM_CH];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   last_vec = 0;
  int   last_err = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference: applies the reconstruction rules directly to the model predictor.
  function automatic void model_step(input int ch, input int r, input int fp,
                                     input int code, input int res,
                                     output int vec, output int err);
    int ac, mag, base, s, lim, v;
    ac  = (code < 0) ? -code : code;
    err = (ac > 16 || r > MAX_R_SIZE) ? 1 : 0;
    if (err != 0) begin
      vec = model_pred[ch];
    end else begin
      base = fp ? (model_pred[ch] >>> 1) : model_pred[ch];
      if (code == 0) begin
        v = base;
      end else begin
        mag = (ac - 1) * (1 << r) + (res % (1 << r)) + 1;
        s   = base + ((code < 0) ? -mag : mag);
        lim = 16 * (1 << r);
        if (s >= lim)      v = s - 2 * lim;
        else if (s < -lim) v = s + 2 * lim;
        else               v = s;
      end
      vec = fp ? 2 * v : v;
      model_pred[ch] = vec;
    end
  endfunction

  // Scoreboard: check the presented result every valid cycle, retire on handshake,
  // and model each accepted input.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", 1, 0);
      end else begin
        chk("out_ch",  int'(out_ch),  exp_q[0].ch);
        chk("out_vec", int'(out_vec), exp_q[0].vec);
        chk("out_err", int'(out_err), exp_q[0].err);
        if (out_ready) begin
          last_vec = int'(out_vec);
          last_err = int'(out_err);
          void'(exp_q.pop_front());
        end
      end
    end
    if (rst) begin
      exp_q.delete();
      for (int i = 0; i < NUM_CH; i++) model_pred[i] = 0;
    end else begin
      if (clr_pred)
        for (int i = 0; i < NUM_CH; i++) model_pred[i] = 0;
      if (in_valid && in_ready) begin
        e.ch = int'(in_ch);
        model_step(int'(in_ch), int'(in_r_size), int'(in_full_pel),
                   int'(in_motion_code), int'(in_motion_residual), e.vec, e.err);
        exp_q.push_back(e);
      end
    end
  end

  task automatic drive(input int ch, input int r, input int fp, input int code, input int res);
    in_ch              = CH_W'(ch);
    in_r_size          = 3'(r);
    in_full_pel        = 1'(fp);
    in_motion_code     = 6'(code);
    in_motion_residual = MAX_R_SIZE'(res);
  endtask

  task automatic send(input int ch, input int r, input int fp, input int code, input int res);
    int n = 0;
    drive(ch, r, fp, code, res);
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic read_pred(input int ch, output int v);
    send(ch, 0, 0, 0, 0);
    drain();
    v = last_vec;
  endtask

  task automatic clear_all();
    clr_pred = 1'b1;
    @(posedge clk);
    #1;
    clr_pred = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v;
    int k;
    int acc;
    int n;
    int hs_code [4];
    int exp_pred;
    hs_code = '{3, 4, 5, 6};

    rst = 1'b1; clr_pred = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drive(0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_ch",    int'(out_ch),    0);
    chk("rst_out_vec",   int'(out_vec),   0);
    chk("rst_out_err",   int'(out_err),   0);
    chk("rst_in_ready",  int'(in_ready),  1);
    for (int c = 0; c < NUM_CH; c++) begin
      read_pred(c, v);
      chk("rst_pred", v, 0);
    end

    // Basic
    clear_all();
    send(0, 1, 0, 3, 1);
    drain();
    chk("basic_first", last_vec, 6);
    send(0, 1, 0, -1, 0);
    drain();
    chk("basic_second", last_vec, 5);

    // Wrap both directions, back-to-back on the same channel
    send(1, 0, 0, 14, 0);
    send(1, 0, 0, 5, 0);
    drain();
    chk("wrap_pos", last_vec, -13);
    send(2, 0, 0, -14, 0);
    send(2, 0, 0, -5, 0);
    drain();
    chk("wrap_neg", last_vec, 13);

    // Full-pel
    send(3, 0, 0, 10, 0);
    send(3, 0, 1, 2, 0);
    drain();
    chk("fullpel_add", last_vec, 14);
    send(3, 0, 0, -7, 0);
    send(3, 0, 1, 0, 0);
    drain();
    chk("fullpel_zero", last_vec, 6);

    // Errors leave the predictor alone (ch0 holds 5)
    send(0, 0, 0, 17, 0);
    drain();
    chk("err_code_flag", last_err, 1);
    chk("err_code_vec",  last_vec, 5);
    send(0, 7, 0, 3, 0);
    drain();
    chk("err_r_flag", last_err, 1);
    chk("err_r_vec",  last_vec, 5);
    send(0, 1, 0, 3, 1);
    drain();
    chk("after_err_flag", last_err, 0);
    chk("after_err_vec",  last_vec, 11);

    // Handshake: backpressure with chained updates on ch2
    clear_all();
    send(0, 0, 0, 3, 0);
    send(1, 0, 0, -7, 0);
    send(3, 0, 0, 11, 0);
    drain();
    out_ready = 1'b0;
    k = 0;
    acc = 0;
    drive(2, 0, 0, hs_code[0], 0);
    in_valid = 1'b1;
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk);
      if (in_ready) begin
        acc++;
        k++;
      end
      @(posedge clk);
      #1;
      if (k < 4) drive(2, 0, 0, hs_code[k], 0);
    end
    chk("hs_accepts", acc, 2);
    chk("hs_in_ready_low", int'(in_ready), 0);
    out_ready = 1'b1;
    n = 0;
    while (k < 4 && n < 50) begin
      @(negedge clk);
      if (in_ready) k++;
      @(posedge clk);
      #1;
      if (k < 4) drive(2, 0, 0, hs_code[k], 0);
      n++;
    end
    in_valid = 1'b0;
    chk("hs_all_sent", k, 4);
    drain();
    chk("hs_last", last_vec, -14);
    read_pred(0, v); chk("hs_ch0", v, 3);
    read_pred(1, v); chk("hs_ch1", v, -7);
    read_pred(3, v); chk("hs_ch3", v, 11);
    read_pred(2, v); chk("hs_ch2", v, -14);

    // Clear coinciding with a Stage B write
    send(1, 0, 0, 2, 0);
    clr_pred = 1'b1;
    @(posedge clk);
    #1;
    clr_pred = 1'b0;
    drain();
    chk("clr_txn", last_vec, -5);
    for (int c = 0; c < NUM_CH; c++) begin
      read_pred(c, v);
      chk("clr_pred", v, 0);
    end

    // Reset mid-stream
    send(2, 0, 0, 4, 0);
    send(2, 0, 0, 4, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_valid", int'(out_valid), 0);
    chk("rst_mid_ch",    int'(out_ch),    0);
    chk("rst_mid_vec",   int'(out_vec),   0);
    chk("rst_mid_err",   int'(out_err),   0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mid_in_ready", int'(in_ready), 1);
    chk("rst_mid_no_out",   int'(out_valid), 0);
    read_pred(2, v);
    chk("rst_mid_pred", v, 0);

    // Randomized traffic with random backpressure
    for (int i = 0; i < 1000; i++) begin
      in_valid  = ($urandom % 10) < 7;
      out_ready = ($urandom % 10) < 7;
      drive(int'($urandom % NUM_CH),
            (($urandom % 16) == 0) ? 7 : int'($urandom_range(0, 6)),
            int'($urandom % 2),
            int'($urandom_range(0, 34)) - 17,
            int'($urandom % 64));
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();
    for (int c = 0; c < NUM_CH; c++) begin
      exp_pred = model_pred[c];
      read_pred(c, v);
      chk("final_pred", v, exp_pred);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
